sensor_frame_builder: RTL
=========================

// Module: sensor_frame_builder
// PURPOSE
//  Upstream feeder for the MLP classifier. Collects a round-robin serial stream of 8-bit
//  sensor samples, one per channel per round. Averages 2**AVG_LOG2 rounds per channel and
//  subtracts a per-channel baseline, clamping the result at zero. Presents one
//  NUM_CH x DW feature frame (the MLP din vector) through a valid/ready handshake.
// PARAMETERS
//  NUM_CH    6                 number of sensor channels = MLP input width
//  DW        8                 sample / feature / baseline width, unsigned
//  AVG_LOG2  2                 log2 of rounds averaged per frame (4 rounds)
//  CH_W      $clog2(NUM_CH)    channel index width (derived)
//  ACC_W     DW+AVG_LOG2       accumulator width (derived); no overflow possible
// PORTS
//  clk_i         in   1            clock, all logic on rising edge
//  rst_i         in   1            synchronous active-high reset
//  s_valid_i     in   1            sample valid
//  s_ready_o     out  1            sample ready
//  s_ch_i        in   CH_W         channel index of sample
//  s_data_i      in   DW           sample value, unsigned
//  base_we_i     in   1            baseline write strobe
//  base_ch_i     in   CH_W         baseline channel to write
//  base_data_i   in   DW           baseline value
//  frame_valid_o out  1            feature frame valid
//  frame_ready_i in   1            downstream accepts frame
//  frame_o       out  DW x NUM_CH  feature frame, unpacked [NUM_CH]
//  seq_err_o     out  1            sticky channel-order error flag
// BEHAVIOUR
//  Reset: state=ACCUM; s_ready_o=1; frame_valid_o=0; frame_o=0; seq_err_o=0.
//   Also clears all accumulators, baselines, exp_ch and round.
//  FSM ACCUM -> CALC -> OUT -> ACCUM.
//   - ACCUM: s_ready_o=1.
//   - CALC, OUT: s_ready_o=0; s_valid_i is ignored.
//  Accept: s_valid_i & s_ready_o on a rising edge.
//   - Correct channel (s_ch_i==exp_ch): acc[exp_ch] += s_data_i. exp_ch increments and
//     wraps NUM_CH-1 -> 0. round increments at each wrap.
//   - Final sample (exp_ch==NUM_CH-1 & round==2**AVG_LOG2-1): accepted at edge E; state
//     becomes CALC.
//  CALC: one cycle. At edge E+1:
//   - frame_o[c] = max(0, (acc[c]>>AVG_LOG2) - base[c]); floor division, unsigned.
//   - Accumulators, exp_ch and round are cleared.
//   - state -> OUT; frame_valid_o=1 from E+1.
//  OUT: frame_o and frame_valid_o hold stable while frame_ready_i=0.
//   - Transfer on an edge with frame_ready_i=1: state -> ACCUM, frame_valid_o -> 0.
//   - frame_o keeps its last value after the transfer.
//   - s_ready_o rises in the same edge's update.
//  Sequence error: an accepted sample with s_ch_i!=exp_ch, including out-of-range indices.
//   - The sample is discarded.
//   - Accumulators, exp_ch and round are cleared; the partial frame is aborted.
//   - seq_err_o is set to 1 and stays set until rst_i.
//  Baseline write: base_we_i=1 writes base[base_ch_i] <= base_data_i in any state.
//   - Out-of-range base_ch_i is ignored.
//   - A write on the CALC edge does not affect that frame; the old value is used.
//  Reset during any state aborts the frame immediately; no partial output.
//  Throughput: one frame per NUM_CH*2**AVG_LOG2 + 2 cycles at best.
// TESTING
//  1. Baselines 0; 4 rounds, every ch c sample = 4c+1 -> frame_o[c]=4c+1;
//     frame_valid_o high exactly 1 edge after the 24th accept.
//  2. base[2]=20, base[3]=50; ch2 samples 10,20,30,40 and ch3 same ->
//     frame_o[2]=5, frame_o[3]=0 (clamped).
//  3. All samples 255, baselines 0 -> frame_o[c]=255 (acc=1020, no overflow).
//  4. Hold frame_ready_i=0 for 5 cycles -> frame_o stable, s_ready_o=0;
//     raise ready -> valid drops next edge and s_ready_o=1.
//  5. Send ch0 then ch2 -> seq_err_o=1, counts reset; a following clean 24-sample frame
//     yields correct values with no residue.
//  6. rst_i after 10 accepted samples -> all outputs at reset values; the next full
//     frame of value 7 yields frame_o[c]=7.

Source files
------------

// File: rtl/sensor_frame_builder.sv
// Collects round-robin sensor samples, averages 2**AVG_LOG2 rounds per channel,
// subtracts a per-channel baseline (clamped at zero) and hands the frame out by valid/ready.
module sensor_frame_builder #(
   parameter int NUM_CH   = 6,
   parameter int DW       = 8,
   parameter int AVG_LOG2 = 2,
   parameter int CH_W     = $clog2(NUM_CH),
   parameter int ACC_W    = DW + AVG_LOG2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            s_valid_i,
   output logic            s_ready_o,
   input  logic [CH_W-1:0] s_ch_i,
   input  logic [DW-1:0]   s_data_i,
   input  logic            base_we_i,
   input  logic [CH_W-1:0] base_ch_i,
   input  logic [DW-1:0]   base_data_i,
   output logic            frame_valid_o,
   input  logic            frame_ready_i,
   output logic [DW-1:0]   frame_o [NUM_CH],
   output logic            seq_err_o
);

   localparam logic [1:0] ST_ACCUM = 2'd0;
   localparam logic [1:0] ST_CALC  = 2'd1;
   localparam logic [1:0] ST_OUT   = 2'd2;

   localparam int              RND_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
   localparam logic [RND_W-1:0] LAST_RND = RND_W'((1 << AVG_LOG2) - 1);

   logic [1:0]       state_q, state_d;
   logic [ACC_W-1:0] acc_q [NUM_CH];
   logic [ACC_W-1:0] acc_d [NUM_CH];
   logic [DW-1:0]    base_q [NUM_CH];
   logic [DW-1:0]    base_d [NUM_CH];
   logic [DW-1:0]    frame_q [NUM_CH];
   logic [DW-1:0]    frame_d [NUM_CH];
   logic [CH_W-1:0]  exp_ch_q, exp_ch_d;
   logic [RND_W-1:0] round_q, round_d;
   logic             frame_valid_q, frame_valid_d;
   logic             seq_err_q, seq_err_d;
   logic             accept;

   // Floor-average of the accumulated rounds minus baseline, clamped at zero.
   function automatic logic [DW-1:0] sub_clamp(input logic [ACC_W-1:0] acc,
                                                input logic [DW-1:0]    base);
      logic [DW-1:0] mean;
      mean = acc[ACC_W-1:AVG_LOG2];
      if (mean > base) return mean - base;
      return '0;
   endfunction

   assign s_ready_o     = (state_q == ST_ACCUM);
   assign accept        = s_valid_i && s_ready_o;
   assign frame_valid_o = frame_valid_q;
   assign frame_o       = frame_q;
   assign seq_err_o     = seq_err_q;

   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      base_d        = base_q;
      frame_d       = frame_q;
      exp_ch_d      = exp_ch_q;
      round_d       = round_q;
      frame_valid_d = frame_valid_q;
      seq_err_d     = seq_err_q;

      case (state_q)
         ST_ACCUM: begin
            if (accept) begin
               if (s_ch_i == exp_ch_q) begin
                  acc_d[exp_ch_q] = acc_q[exp_ch_q] + ACC_W'(s_data_i);
                  if (exp_ch_q == LAST_CH) begin
                     exp_ch_d = '0;
                     round_d  = round_q + RND_W'(1);
                     if (round_q == LAST_RND) state_d = ST_CALC;
                  end else begin
                     exp_ch_d = exp_ch_q + CH_W'(1);
                  end
               end else begin
                  // Out-of-order sample: drop it and abort the partial frame.
                  for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
                  exp_ch_d  = '0;
                  round_d   = '0;
                  seq_err_d = 1'b1;
               end
            end
         end
         ST_CALC: begin
            for (int c = 0; c < NUM_CH; c++) begin
               frame_d[c] = sub_clamp(acc_q[c], base_q[c]);
               acc_d[c]   = '0;
            end
            exp_ch_d      = '0;
            round_d       = '0;
            frame_valid_d = 1'b1;
            state_d       = ST_OUT;
         end
         ST_OUT: begin
            if (frame_ready_i) begin
               frame_valid_d = 1'b0;
               state_d       = ST_ACCUM;
            end
         end
         default: state_d = ST_ACCUM;
      endcase

      // Baseline writes land after this edge, so a write on the CALC edge affects only later frames.
      if (base_we_i && (int'(base_ch_i) < NUM_CH)) base_d[base_ch_i] = base_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_ACCUM;
         exp_ch_q      <= '0;
         round_q       <= '0;
         frame_valid_q <= 1'b0;
         seq_err_q     <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            acc_q[c]   <= '0;
            base_q[c]  <= '0;
            frame_q[c] <= '0;
         end
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         base_q        <= base_d;
         frame_q       <= frame_d;
         exp_ch_q      <= exp_ch_d;
         round_q       <= round_d;
         frame_valid_q <= frame_valid_d;
         seq_err_q     <= seq_err_d;
      end
   end

endmodule
